led_sequencer_wb: RTL and testbench
===================================

LED_SEQUENCER_WB -- requirements
Module: led_sequencer_wb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width in bits.
REQ-003 SHALL have parameter LED_ADDR, default 0, target address of the LED register.
REQ-004 SHALL have parameter PRESCALE_WIDTH, default 24, width of the period input.
REQ-005 SHALL have parameter TIMEOUT, default 16, maximum cycles a bus cycle waits for termination.
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port enable, input, 1, sequencer run.
REQ-009 SHALL have port mode, input, 2, 0 static, 1 blink, 2 chase, 3 count.
REQ-010 SHALL have port period, input, PRESCALE_WIDTH, step interval in clk cycles minus one.
REQ-011 SHALL have port pattern, input, 6, LED pattern for static and blink modes.
REQ-012 SHALL have port err_clr, input, 1, clears sticky error.
REQ-013 SHALL have ports wb_adr_o (ADDR_WIDTH), wb_dat_o (DATA_WIDTH), wb_sel_o (DATA_WIDTH/8), wb_we_o, wb_stb_o and wb_cyc_o, all outputs: Wishbone master request.
REQ-014 SHALL have ports wb_ack_i and wb_err_i, inputs, 1 each, Wishbone termination.
REQ-015 SHALL have port busy, output, 1, high while a bus cycle is active.
REQ-016 SHALL have port err, output, 1, sticky flag for bus error or timeout.

Function
REQ-017 SHALL have prescaler counting 0..period, emitting a 1-cycle tick at count==period and then restarting at 0; period=0 gives a tick every cycle.
REQ-018 SHALL hold the prescaler at 0 with no ticks while enable=0.
REQ-019 SHALL raise a write request on the cycle after an enable 0->1 edge, immediately, without waiting for a tick.
REQ-020 SHALL raise a write request on every tick while enable=1.
REQ-021 SHALL compute step values as follows: static = pattern every step; blink = pattern, then 0, alternating, starting with pattern; chase = one-hot 000001 shifted left each step, wrapping 100000->000001; count = 6-bit binary incrementing each step, starting at 0, wrapping 63->0.
REQ-022 SHALL zero-extend the step value to DATA_WIDTH on wb_dat_o.
REQ-023 SHALL advance the step state only when a write is terminated by ack.
REQ-024 SHALL reset the step state to its start value when mode changes or on an enable rising edge.
REQ-025 SHALL use FSM states IDLE, BUS and HOLD.
REQ-026 SHALL move IDLE->BUS when a request or pending flag is set.
REQ-027 SHALL assert cyc, stb and we in BUS, with sel all ones and adr=LED_ADDR.
REQ-028 SHALL make the BUS->HOLD transition on wb_ack_i, on wb_err_i, or when TIMEOUT cycles elapse without termination.
REQ-029 SHALL deassert cyc/stb in HOLD and return to IDLE on the next cycle; minimum spacing is therefore 1 idle cycle between bus cycles.
REQ-030 SHALL give a single-cycle ack slave a BUS duration of exactly 1 cycle.
REQ-031 SHALL drive wb_dat_o and wb_adr_o stable throughout BUS.
REQ-032 SHALL latch a tick arriving during BUS or HOLD into a 1-deep pending flag; further ticks coalesce into that flag and the pending write uses the step value current at issue.
REQ-033 SHALL let a write already in BUS complete normally when enable falls; pending is cleared and no new cycle starts.
REQ-034 SHALL prioritise wb_err_i over wb_ack_i when both are asserted in the same cycle.
REQ-035 SHALL set err on wb_err_i or on timeout; the step does not advance in either case.
REQ-036 SHALL clear err on err_clr; if err_clr and a new error coincide, err stays set.
REQ-037 SHALL drive busy = 1 exactly when the FSM is in BUS.

Reset
REQ-038 SHALL, on rst, set the FSM to IDLE and clear the prescaler, pending flag, step state, err and busy.
REQ-039 SHALL hold wb_cyc_o, wb_stb_o and wb_we_o at 0 and wb_dat_o at 0 after reset.
REQ-040 SHALL drop cyc/stb on the next edge when rst is asserted mid-cycle, and SHALL not set err as a result.
REQ-041 SHALL treat enable already high at rst release as a rising edge.

Verification
REQ-042 SHALL cover: mode=2, period=3, ack slave with 0 wait states -> writes 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x01, with the first on the cycle after enable and subsequent writes 4 cycles apart.
REQ-043 SHALL cover: mode=1, pattern=0x2A, period=0 -> alternating 0x2A, 0x00, with 1 idle cycle between bus cycles.
REQ-044 SHALL cover: slave never acks, TIMEOUT=16 -> cyc high exactly 16 cycles, then err=1, the same value is retried on the next tick, and err_clr returns err to 0.
REQ-045 SHALL cover: slave with 10 wait states and period=0 -> exactly one pending write issued after ack, and no ticks lost beyond coalescing.
REQ-046 SHALL cover: mode=3 run past 63 -> wrap to 0x00; a mode change mid-run restarts at the start value of the new mode.
REQ-047 SHALL cover: rst asserted during BUS -> cyc=0 on the next cycle, all outputs at reset values, and err=0.

Source files
------------

// File: rtl/led_sequencer_wb.sv
// LED pattern sequencer that pushes each step value to a Wishbone LED register.
// Prescaled ticks request writes; ticks during a bus cycle coalesce into one pending write.
module led_sequencer_wb #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] LED_ADDR       = '0,
   parameter int                    PRESCALE_WIDTH = 24,
   parameter int                    TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [1:0]                mode,
   input  logic [PRESCALE_WIDTH-1:0] period,
   input  logic [5:0]                pattern,
   input  logic                      err_clr,
   output logic [ADDR_WIDTH-1:0]     wb_adr_o,
   output logic [DATA_WIDTH-1:0]     wb_dat_o,
   output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
   output logic                      wb_we_o,
   output logic                      wb_stb_o,
   output logic                      wb_cyc_o,
   input  logic                      wb_ack_i,
   input  logic                      wb_err_i,
   output logic                      busy,
   output logic                      err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;

   state_t                    state, state_nxt;
   logic [PRESCALE_WIDTH-1:0] cnt;
   logic                      enable_q;
   logic [1:0]                mode_q;
   logic                      pending;
   logic [5:0]                step;
   logic                      stale;
   logic [TW-1:0]             tcnt;
   logic [DATA_WIDTH-1:0]     dat_q;
   logic                      err_q;

   logic       rise, restart, tick, timeout;
   logic       issue, done_ok, done_bad;
   logic [5:0] step_eff;

   function automatic logic [5:0] start_of(input logic [1:0] m);
      return (m == 2'd2) ? 6'd1 : 6'd0;
   endfunction

   function automatic logic [5:0] value_of(input logic [1:0] m, input logic [5:0] s,
                                           input logic [5:0] pat);
      logic [5:0] r;
      r = s;
      case (m)
         2'd0:    r = pat;
         2'd1:    r = s[0] ? 6'd0 : pat;
         default: r = s;
      endcase
      return r;
   endfunction

   function automatic logic [5:0] advance(input logic [1:0] m, input logic [5:0] s);
      logic [5:0] r;
      r = s;
      case (m)
         2'd1:    r = {5'd0, ~s[0]};
         2'd2:    r = {s[4:0], s[5]};
         2'd3:    r = s + 6'd1;
         default: r = s;
      endcase
      return r;
   endfunction

   assign rise     = enable & ~enable_q;
   assign restart  = rise | (mode != mode_q);
   // The prescaler restarts on the enable edge, so the edge itself never ticks.
   assign tick     = enable & enable_q & (cnt == period);
   assign timeout  = (tcnt == TW'(TIMEOUT - 1));
   assign step_eff = restart ? start_of(mode) : step;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_ok   = 1'b0;
      done_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (rise || tick || pending)) begin
               state_nxt = BUS;
               issue     = 1'b1;
            end
         end
         BUS: begin
            if (wb_err_i) begin
               state_nxt = HOLD;
               done_bad  = 1'b1;
            end else if (wb_ack_i) begin
               state_nxt = HOLD;
               done_ok   = 1'b1;
            end else if (timeout) begin
               state_nxt = HOLD;
               done_bad  = 1'b1;
            end
         end
         HOLD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         enable_q <= 1'b0;
         mode_q   <= 2'd0;
         pending  <= 1'b0;
         step     <= 6'd0;
         stale    <= 1'b0;
         tcnt     <= '0;
         dat_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         enable_q <= enable;
         mode_q   <= mode;

         if (!enable || rise || cnt == period) cnt <= '0;
         else                                  cnt <= cnt + PRESCALE_WIDTH'(1);

         if (!enable || issue)                      pending <= 1'b0;
         else if ((tick || rise) && state != IDLE)  pending <= 1'b1;

         // A write launched before a restart must not advance the fresh sequence.
         if (issue)                          stale <= 1'b0;
         else if (restart && state != IDLE)  stale <= 1'b1;

         if (restart)                step <= start_of(mode);
         else if (done_ok && !stale) step <= advance(mode, step);

         if (issue) begin
            dat_q <= DATA_WIDTH'(value_of(mode, step_eff, pattern));
            tcnt  <= '0;
         end else if (state == BUS) begin
            tcnt  <= tcnt + TW'(1);
         end

         err_q <= (err_q & ~err_clr) | done_bad;
      end
   end

   assign wb_cyc_o = (state == BUS);
   assign wb_stb_o = (state == BUS);
   assign wb_we_o  = (state == BUS);
   assign wb_adr_o = LED_ADDR;
   assign wb_sel_o = '1;
   assign wb_dat_o = dat_q;
   assign busy     = (state == BUS);
   assign err      = err_q;

endmodule

// File: tb/tb_led_sequencer_wb.sv
// Bench for led_sequencer_wb: table-driven mode vectors plus hand-written corner sequences,
// with a Wishbone slave model that checks each acked write against a queue of expected values.
`timescale 1ns/1ps
module tb_led_sequencer_wb;

   localparam logic [31:0] LED_A = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, enable, err_clr;
   logic [1:0]  mode;
   logic [23:0] period;
   logic [5:0]  pattern;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_stb_o, wb_cyc_o;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
   logic        busy, err;

   always #5 clk = ~clk;

   led_sequencer_wb #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .LED_ADDR(LED_A), .PRESCALE_WIDTH(24), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period), .pattern(pattern),
      .err_clr(err_clr), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .busy(busy), .err(err)
   );

   int total = 0;
   int bad   = 0;
   int cyc_num = 0;
   always @(posedge clk) cyc_num++;

   logic [5:0] expq[$];
   int         starts[$];
   int         nwrites = 0;
   int         last_len = 0;
   int         wait_states = 0;
   bit         never_ack = 1'b0;
   bit         give_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_num);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired, %0d expected writes outstanding", name, expq.size());
   endtask

   // Slave model and monitor: acks after wait_states cycles and scores each acked write.
   int   bcnt = 0;
   int   run = 0;
   logic cyc_prev = 1'b0;
   always @(negedge clk) begin
      chk("busy_vs_cyc", 32'(busy), 32'(wb_cyc_o));
      if (wb_cyc_o && !cyc_prev) begin
         starts.push_back(cyc_num);
         run = 0;
      end
      if (!wb_cyc_o && cyc_prev) last_len = run;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) begin
         run++;
         if (!never_ack && bcnt == wait_states) begin
            wb_ack_i = 1'b1;
            wb_err_i = give_err;
            if (!give_err) begin
               nwrites++;
               chk("wr_adr", wb_adr_o, LED_A);
               chk("wr_sel_we_stb", {28'd0, wb_sel_o} | {31'd0, wb_we_o & wb_stb_o} << 4,
                   32'h1F);
               if (expq.size() > 0) chk("wr_dat", wb_dat_o, 32'(expq.pop_front()));
            end
         end
         bcnt++;
      end else begin
         bcnt = 0;
      end
      cyc_prev = wb_cyc_o;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (expq.size() != 0) begin
         timeout_fail(name);
         expq.delete();
      end
      cycles(1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (wb_cyc_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (wb_cyc_o) timeout_fail("wait_idle");
      cycles(3);
   endtask

   task automatic wait_cyc(input logic level, input string name);
      int n = 0;
      while (wb_cyc_o !== level && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (wb_cyc_o !== level) timeout_fail(name);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [5:0]  pattern;
      logic [23:0] period;
      int          n;
      int          gap;      // exact start spacing, 0 = only require an idle gap
      logic [5:0]  exp [8];
   } vec_t;

   vec_t vecs[4];

   initial begin
      int c0;
      int n0;
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int n0;
      vecs[0] = '{mode: 2'd2, pattern: 6'h00, period: 24'd3, n: 7, gap: 4,
                  exp: '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01, 6'h00}};
      vecs[1] = '{mode: 2'd1, pattern: 6'h2A, period: 24'd0, n: 6, gap: 0,
                  exp: '{6'h2A, 6'h00, 6'h2A, 6'h00, 6'h2A, 6'h00, 6'h00, 6'h00}};
      vecs[2] = '{mode: 2'd0, pattern: 6'h15, period: 24'd1, n: 4, gap: 0,
                  exp: '{6'h15, 6'h15, 6'h15, 6'h15, 6'h00, 6'h00, 6'h00, 6'h00}};
      vecs[3] = '{mode: 2'd3, pattern: 6'h3F, period: 24'd0, n: 6, gap: 0,
                  exp: '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h00, 6'h00}};

      rst = 1'b1; enable = 1'b0; err_clr = 1'b0; mode = 2'd0; period = 24'd0; pattern = 6'd0;
      cycles(3);
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_we", 32'(wb_we_o), 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      cycles(2);

      for (int v = 0; v < 4; v++) begin
         mode = vecs[v].mode; pattern = vecs[v].pattern; period = vecs[v].period;
         cycles(2);
         starts.delete();
         for (int j = 0; j < vecs[v].n; j++) expq.push_back(vecs[v].exp[j]);
         c0 = cyc_num;
         enable = 1'b1;
         wait_empty($sformatf("vec%0d_writes", v), 400);
         chk($sformatf("vec%0d_first_start", v), 32'(starts.size() > 0 ? starts[0] - c0 : -1), 32'd1);
         for (int i = 1; i < vecs[v].n && i < starts.size(); i++) begin
            if (vecs[v].gap != 0)
               chk($sformatf("vec%0d_spacing%0d", v, i), 32'(starts[i] - starts[i-1]), 32'(vecs[v].gap));
            else
               chk($sformatf("vec%0d_idle_gap%0d", v, i), 32'(starts[i] - starts[i-1] >= 2), 32'd1);
         end
         enable = 1'b0;
         wait_idle();
      end

      // Slave never responds: 16-cycle timeout, sticky err, same value retried on the next tick.
      mode = 2'd2; period = 24'd40; never_ack = 1'b1;
      cycles(2);
      starts.delete();
      enable = 1'b1;
      wait_cyc(1'b1, "to_start");
      wait_cyc(1'b0, "to_end");
      cycles(1);
      chk("timeout_len", 32'(last_len), 32'd16);
      chk("timeout_err", 32'(err), 32'd1);
      never_ack = 1'b0;
      expq.push_back(6'h01);
      wait_empty("timeout_retry", 100);
      chk("retry_on_tick", 32'(starts.size() > 1 ? starts[1] - starts[0] : -1), 32'd41);
      chk("err_sticky", 32'(err), 32'd1);
      enable = 1'b0;
      wait_idle();
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      chk("err_cleared", 32'(err), 32'd0);

      // err and ack together with err_clr on the same edge: err wins, step holds.
      give_err = 1'b1;
      starts.delete();
      enable = 1'b1;
      err_clr = 1'b1;
      cycles(2);
      err_clr = 1'b0;
      chk("err_over_clr", 32'(err), 32'd1);
      give_err = 1'b0;
      expq.push_back(6'h01);
      wait_empty("err_no_advance", 100);
      enable = 1'b0;
      wait_idle();
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      chk("err_cleared2", 32'(err), 32'd0);

      // Slow slave, period 0: ticks coalesce into one pending write per bus cycle.
      mode = 2'd3; period = 24'd0; wait_states = 10;
      cycles(2);
      starts.delete();
      for (int j = 0; j < 4; j++) expq.push_back(6'(j));
      enable = 1'b1;
      begin
         int n = 0;
         while (starts.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      cycles(3);
      enable = 1'b0;
      wait_empty("pend_writes", 50);
      n0 = nwrites;
      cycles(30);
      chk("pend_no_extra_writes", 32'(nwrites - n0), 32'd0);
      chk("pend_start_count", 32'(starts.size()), 32'd4);
      for (int i = 1; i < 4 && i < starts.size(); i++)
         chk($sformatf("pend_spacing%0d", i), 32'(starts[i] - starts[i-1]), 32'd13);
      wait_states = 0;

      // Count wraps past 63, then a mid-run mode change restarts chase at 0x01.
      mode = 2'd3; period = 24'd0;
      cycles(2);
      for (int j = 0; j < 64; j++) expq.push_back(6'(j));
      expq.push_back(6'h00);
      expq.push_back(6'h01);
      enable = 1'b1;
      wait_empty("count_wrap", 400);
      wait_cyc(1'b1, "mode_chg_sync");
      mode = 2'd2;
      cycles(1);
      wait_cyc(1'b0, "mode_chg_drain");
      expq.push_back(6'h01);
      expq.push_back(6'h02);
      expq.push_back(6'h04);
      wait_empty("mode_change_restart", 100);
      enable = 1'b0;
      wait_idle();

      // Reset in the middle of a bus cycle, then enable already high at release.
      mode = 2'd2; period = 24'd0; wait_states = 10;
      enable = 1'b1;
      wait_cyc(1'b1, "rst_mid_start");
      cycles(2);
      rst = 1'b1;
      cycles(1);
      chk("rstbus_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rstbus_stb_we", 32'({wb_stb_o, wb_we_o}), 32'd0);
      chk("rstbus_dat", wb_dat_o, 32'd0);
      chk("rstbus_err", 32'(err), 32'd0);
      wait_states = 0;
      cycles(2);
      starts.delete();
      expq.push_back(6'h01);
      c0 = cyc_num;
      rst = 1'b0;
      wait_empty("rst_release_write", 50);
      chk("rst_release_edge", 32'(starts.size() > 0 ? starts[0] - c0 : -1), 32'd1);
      chk("rst_release_err", 32'(err), 32'd0);
      enable = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
